// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780-compatible display-side responder for the 4-bit LCD bus
// Assembles E-strobed nibbles, decodes instructions, keeps an 80-byte DDRAM and busy timing.
module lcd_hd44780_responder #(
   parameter int BUSY_SHORT = 3700,
   parameter int BUSY_LONG  = 152000,
   parameter int E_MIN_HIGH = 23
) (
   input  logic        Clock_100MHz,
   input  logic        Clear,
   input  logic        LCD_E,
   input  logic        LCD_RS,
   input  logic        LCD_RW,
   input  logic [3:0]  LCD_DB,
   output logic [3:0]  LCD_DB_out,
   output logic        LCD_DB_oe,
   input  logic [6:0]  rd_addr,
   output logic [7:0]  rd_char,
   output logic [6:0]  ac,
   output logic        busy,
   output logic        four_bit_mode,
   output logic        two_line,
   output logic        display_on,
   output logic        cursor_on,
   output logic        blink_on,
   output logic        protocol_error,
   output logic        timing_error,
   output logic [15:0] byte_count
);
   localparam int BMAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
   localparam int BW   = $clog2(BMAX + 1);
   localparam int EW   = $clog2(E_MIN_HIGH + 1);

   function automatic logic ac_valid(input logic [6:0] a);
      return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
   endfunction

   function automatic logic [6:0] ddr_idx(input logic [6:0] a);
      return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
   endfunction

   // Line-aware AC stepping; addresses outside the active map step as plain 7-bit values.
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic two, input logic inc);
      logic [6:0] r;
      r = inc ? a + 7'd1 : a - 7'd1;
      if (two && ac_valid(a)) begin
         if (inc && a == 7'h27)       r = 7'h40;
         else if (inc && a == 7'h67)  r = 7'h00;
         else if (!inc && a == 7'h00) r = 7'h67;
         else if (!inc && a == 7'h40) r = 7'h27;
      end else if (!two && a <= 7'h4F) begin
         if (inc && a == 7'h4F)       r = 7'h00;
         else if (!inc && a == 7'h00) r = 7'h4F;
      end
      return r;
   endfunction

   logic          e_q, rs_q, rw_q;
   logic [3:0]    db_q;
   logic [EW-1:0] e_cnt_q, e_cnt_d;
   logic          phase_lo_q, phase_lo_d;
   logic [3:0]    hi_q, hi_d;
   logic          hi_rs_q, hi_rs_d;
   logic [6:0]    ac_q, ac_d;
   logic          id_q, id_d;
   logic          four_q, four_d, two_q, two_d;
   logic          disp_q, disp_d, curs_q, curs_d, blink_q, blink_d;
   logic          perr_q, perr_d, terr_q, terr_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [BW-1:0] busy_cnt_q, busy_cnt_d;
   logic [7:0]    rd_char_q;
   logic [7:0]    mem_q [80];

   logic          strobe, exec, exec_rs, clr_all, wr_en;
   logic [7:0]    exec_byte, rd_byte;

   assign busy = (busy_cnt_q != '0);

   always_comb begin
      e_cnt_d    = LCD_E ? ((e_cnt_q == EW'(E_MIN_HIGH)) ? e_cnt_q : e_cnt_q + 1'b1) : '0;
      phase_lo_d = phase_lo_q;
      hi_d       = hi_q;
      hi_rs_d    = hi_rs_q;
      ac_d       = ac_q;
      id_d       = id_q;
      four_d     = four_q;
      two_d      = two_q;
      disp_d     = disp_q;
      curs_d     = curs_q;
      blink_d    = blink_q;
      perr_d     = perr_q;
      terr_d     = terr_q;
      cnt_d      = cnt_q;
      busy_cnt_d = busy ? busy_cnt_q - 1'b1 : busy_cnt_q;
      strobe     = e_q && !LCD_E;
      exec       = 1'b0;
      exec_byte  = {db_q, 4'h0};
      exec_rs    = rs_q;
      clr_all    = 1'b0;
      wr_en      = 1'b0;

      if (strobe) begin
         if (e_cnt_q < EW'(E_MIN_HIGH)) terr_d = 1'b1;
         if (rw_q) begin
            if (four_q) phase_lo_d = !phase_lo_q;
            if (rs_q && (!four_q || phase_lo_q)) ac_d = ac_step(ac_q, two_q, id_q);
         end else if (busy) begin
            perr_d = 1'b1;
         end else if (!four_q) begin
            exec = 1'b1;
         end else if (!phase_lo_q) begin
            hi_d       = db_q;
            hi_rs_d    = rs_q;
            phase_lo_d = 1'b1;
         end else begin
            exec       = 1'b1;
            exec_byte  = {hi_q, db_q};
            exec_rs    = hi_rs_q;
            phase_lo_d = 1'b0;
         end
      end

      // Display shift (S) has no visible effect in this model, so it is not kept.
      if (exec) begin
         cnt_d      = cnt_q + 16'd1;
         busy_cnt_d = BW'(BUSY_SHORT);
         if (exec_rs) begin
            wr_en = ac_valid(ac_q);
            ac_d  = ac_step(ac_q, two_q, id_q);
         end else if (exec_byte[7]) begin
            ac_d = exec_byte[6:0];
         end else if (exec_byte[6]) begin
            cnt_d = cnt_q + 16'd1;
         end else if (exec_byte[5]) begin
            if (!exec_byte[4]) begin
               four_d     = 1'b1;
               phase_lo_d = 1'b0;
            end
            two_d = exec_byte[3];
         end else if (exec_byte[4]) begin
            if (!exec_byte[3]) ac_d = ac_step(ac_q, two_q, exec_byte[2]);
         end else if (exec_byte[3]) begin
            {disp_d, curs_d, blink_d} = exec_byte[2:0];
         end else if (exec_byte[2]) begin
            id_d = exec_byte[1];
         end else if (exec_byte[1]) begin
            ac_d       = 7'h00;
            busy_cnt_d = BW'(BUSY_LONG);
         end else if (exec_byte[0]) begin
            clr_all    = 1'b1;
            ac_d       = 7'h00;
            id_d       = 1'b1;
            busy_cnt_d = BW'(BUSY_LONG);
         end
      end
   end

   always_comb begin
      rd_byte   = ac_valid(ac_q) ? mem_q[ddr_idx(ac_q)] : 8'h00;
      LCD_DB_oe = LCD_E && LCD_RW;
      if (!LCD_DB_oe)  LCD_DB_out = 4'h0;
      else if (!LCD_RS) LCD_DB_out = phase_lo_q ? ac_q[3:0] : {busy, ac_q[6:4]};
      else              LCD_DB_out = phase_lo_q ? rd_byte[3:0] : rd_byte[7:4];
   end

   always_ff @(posedge Clock_100MHz) begin
      if (Clear) begin
         e_q        <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         db_q       <= 4'h0;
         e_cnt_q    <= '0;
         phase_lo_q <= 1'b0;
         hi_q       <= 4'h0;
         hi_rs_q    <= 1'b0;
         ac_q       <= 7'h00;
         id_q       <= 1'b1;
         four_q     <= 1'b0;
         two_q      <= 1'b0;
         disp_q     <= 1'b0;
         curs_q     <= 1'b0;
         blink_q    <= 1'b0;
         perr_q     <= 1'b0;
         terr_q     <= 1'b0;
         cnt_q      <= 16'h0000;
         busy_cnt_q <= '0;
         rd_char_q  <= 8'h00;
         for (int i = 0; i < 80; i++) mem_q[i] <= 8'h20;
      end else begin
         e_q        <= LCD_E;
         rs_q       <= LCD_RS;
         rw_q       <= LCD_RW;
         db_q       <= LCD_DB;
         e_cnt_q    <= e_cnt_d;
         phase_lo_q <= phase_lo_d;
         hi_q       <= hi_d;
         hi_rs_q    <= hi_rs_d;
         ac_q       <= ac_d;
         id_q       <= id_d;
         four_q     <= four_d;
         two_q      <= two_d;
         disp_q     <= disp_d;
         curs_q     <= curs_d;
         blink_q    <= blink_d;
         perr_q     <= perr_d;
         terr_q     <= terr_d;
         cnt_q      <= cnt_d;
         busy_cnt_q <= busy_cnt_d;
         rd_char_q  <= ac_valid(rd_addr) ? mem_q[ddr_idx(rd_addr)] : 8'h00;
         if (clr_all) begin
            for (int i = 0; i < 80; i++) mem_q[i] <= 8'h20;
         end else if (wr_en) begin
            mem_q[ddr_idx(ac_q)] <= exec_byte;
         end
      end
   end

   assign rd_char        = rd_char_q;
   assign ac             = ac_q;
   assign four_bit_mode  = four_q;
   assign two_line       = two_q;
   assign display_on     = disp_q;
   assign cursor_on      = curs_q;
   assign blink_on       = blink_q;
   assign protocol_error = perr_q;
   assign timing_error   = terr_q;
   assign byte_count     = cnt_q;
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb/tb_lcd_hd44780_responder.sv - directed self-checking bench for lcd_hd44780_responder
// Shortened busy windows keep the run small; expected values are hand-derived.
module tb_lcd_hd44780_responder;
   localparam int BS = 100;
   localparam int BL = 400;
   localparam int EM = 23;

   logic        clk = 1'b0;
   logic        Clear = 1'b1;
   logic        LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
   logic [3:0]  LCD_DB = 4'h0;
   logic [3:0]  LCD_DB_out;
   logic        LCD_DB_oe;
   logic [6:0]  rd_addr = 7'h00;
   logic [7:0]  rd_char;
   logic [6:0]  ac;
   logic        busy, four_bit_mode, two_line, display_on, cursor_on, blink_on;
   logic        protocol_error, timing_error;
   logic [15:0] byte_count;

   int tests = 0;
   int fails = 0;
   int exp_bc = 0;

   lcd_hd44780_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL), .E_MIN_HIGH(EM)) dut (
      .Clock_100MHz(clk), .Clear(Clear), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .LCD_DB(LCD_DB), .LCD_DB_out(LCD_DB_out), .LCD_DB_oe(LCD_DB_oe), .rd_addr(rd_addr),
      .rd_char(rd_char), .ac(ac), .busy(busy), .four_bit_mode(four_bit_mode),
      .two_line(two_line), .display_on(display_on), .cursor_on(cursor_on),
      .blink_on(blink_on), .protocol_error(protocol_error), .timing_error(timing_error),
      .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at 2 ms, required finish");
      $fatal(1);
   end

   task automatic pulse(input logic rs, input logic rw, input logic [3:0] nib, input int n);
      @(negedge clk);
      LCD_RS = rs; LCD_RW = rw; LCD_DB = nib; LCD_E = 1'b1;
      repeat (n) @(negedge clk);
      LCD_E = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (busy && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (busy) begin
         tests++; fails++;
         $display("FAIL wait_ready: busy=1 after %0d cycles, required 0", guard);
      end
   endtask

   task automatic write_nib8(input logic [3:0] nib);
      wait_ready();
      pulse(1'b0, 1'b0, nib, EM);
      exp_bc++;
   endtask

   task automatic write_byte(input logic rs, input logic [7:0] b);
      wait_ready();
      pulse(rs, 1'b0, b[7:4], EM);
      pulse(rs, 1'b0, b[3:0], EM);
      exp_bc++;
   endtask

   task automatic read_nibble(input logic rs, output logic [3:0] nib, output logic oe_hi, output logic oe_after);
      @(negedge clk);
      LCD_RS = rs; LCD_RW = 1'b1; LCD_E = 1'b1;
      repeat (EM) @(negedge clk);
      nib = LCD_DB_out; oe_hi = LCD_DB_oe;
      LCD_E = 1'b0;
      #1 oe_after = LCD_DB_oe;
      @(negedge clk);
      LCD_RW = 1'b0;
   endtask

   task automatic peek(input logic [6:0] a, output logic [7:0] v);
      rd_addr = a;
      @(negedge clk);
      v = rd_char;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      Clear = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (rd_char !== 8'h00) begin fails++; $display("FAIL reset_rd_char: got %h want 00", rd_char); end
      Clear = 1'b0;
      exp_bc = 0;
      tests++; if ({four_bit_mode, two_line, display_on, cursor_on, blink_on, busy} !== 6'b0) begin
         fails++; $display("FAIL reset_flags: got %b want 000000", {four_bit_mode, two_line, display_on, cursor_on, blink_on, busy}); end
      tests++; if ({protocol_error, timing_error, LCD_DB_oe} !== 3'b0 || LCD_DB_out !== 4'h0) begin
         fails++; $display("FAIL reset_err_bus: got %b/%h want 000/0", {protocol_error, timing_error, LCD_DB_oe}, LCD_DB_out); end
      tests++; if (ac !== 7'h00 || byte_count !== 16'd0) begin fails++; $display("FAIL reset_ac_count: got %h/%0d want 00/0", ac, byte_count); end
      peek(7'h00, v);
      tests++; if (v !== 8'h20) begin fails++; $display("FAIL reset_ddram0: got %h want 20", v); end
      peek(7'h67, v);
      tests++; if (v !== 8'h20) begin fails++; $display("FAIL reset_ddram67: got %h want 20", v); end
      peek(7'h30, v);
      tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_invalid_addr: got %h want 00", v); end
   endtask

   task automatic test_init();
      int blen = 0;
      write_nib8(4'h3); write_nib8(4'h3); write_nib8(4'h3); write_nib8(4'h2);
      tests++; if (four_bit_mode !== 1'b1) begin fails++; $display("FAIL init_4bit_after_nibbles: got %b want 1", four_bit_mode); end
      write_byte(1'b0, 8'h28); write_byte(1'b0, 8'h06); write_byte(1'b0, 8'h0F); write_byte(1'b0, 8'h01);
      while (busy && blen < 1000) begin
         blen++;
         @(negedge clk);
      end
      tests++; if (blen != BL) begin fails++; $display("FAIL init_busy_len: got %0d want %0d", blen, BL); end
      tests++; if ({four_bit_mode, two_line, display_on, cursor_on, blink_on} !== 5'b11111) begin
         fails++; $display("FAIL init_flags: got %b want 11111", {four_bit_mode, two_line, display_on, cursor_on, blink_on}); end
      tests++; if (ac !== 7'h00) begin fails++; $display("FAIL init_ac: got %h want 00", ac); end
      tests++; if (byte_count !== 16'd8) begin fails++; $display("FAIL init_byte_count: got %0d want 8", byte_count); end
      tests++; if (timing_error !== 1'b0 || protocol_error !== 1'b0) begin
         fails++; $display("FAIL init_errors: got %b%b want 00", timing_error, protocol_error); end
   endtask

   task automatic test_text();
      logic [7:0] v;
      write_byte(1'b1, 8'h48); write_byte(1'b1, 8'h69); write_byte(1'b0, 8'hC0); write_byte(1'b1, 8'h41);
      peek(7'h00, v);
      tests++; if (v !== 8'h48) begin fails++; $display("FAIL text_ddram00: got %h want 48", v); end
      peek(7'h01, v);
      tests++; if (v !== 8'h69) begin fails++; $display("FAIL text_ddram01: got %h want 69", v); end
      peek(7'h40, v);
      tests++; if (v !== 8'h41) begin fails++; $display("FAIL text_ddram40: got %h want 41", v); end
      peek(7'h02, v);
      tests++; if (v !== 8'h20) begin fails++; $display("FAIL text_ddram02: got %h want 20", v); end
      tests++; if (ac !== 7'h41) begin fails++; $display("FAIL text_ac: got %h want 41", ac); end
   endtask

   task automatic test_wrap();
      logic [7:0] v;
      write_byte(1'b0, 8'hA7); write_byte(1'b1, 8'h58);
      peek(7'h27, v);
      tests++; if (v !== 8'h58) begin fails++; $display("FAIL wrap_ddram27: got %h want 58", v); end
      tests++; if (ac !== 7'h40) begin fails++; $display("FAIL wrap_inc_ac: got %h want 40", ac); end
      write_byte(1'b0, 8'h04); write_byte(1'b0, 8'h80); write_byte(1'b1, 8'h59);
      tests++; if (ac !== 7'h67) begin fails++; $display("FAIL wrap_dec_ac: got %h want 67", ac); end
      peek(7'h00, v);
      tests++; if (v !== 8'h59) begin fails++; $display("FAIL wrap_ddram00: got %h want 59", v); end
      write_byte(1'b0, 8'h06);
   endtask

   task automatic test_busy_read();
      logic [3:0] nib;
      logic oe_hi, oe_after;
      write_byte(1'b0, 8'h01);
      read_nibble(1'b0, nib, oe_hi, oe_after);
      tests++; if (nib !== 4'h8) begin fails++; $display("FAIL bread_hi_busy: got %h want 8", nib); end
      tests++; if (oe_hi !== 1'b1 || oe_after !== 1'b0) begin fails++; $display("FAIL bread_oe: got %b%b want 10", oe_hi, oe_after); end
      read_nibble(1'b0, nib, oe_hi, oe_after);
      tests++; if (nib !== 4'h0) begin fails++; $display("FAIL bread_lo_busy: got %h want 0", nib); end
      wait_ready();
      read_nibble(1'b0, nib, oe_hi, oe_after);
      tests++; if (nib !== 4'h0) begin fails++; $display("FAIL bread_hi_idle: got %h want 0", nib); end
      read_nibble(1'b0, nib, oe_hi, oe_after);
      tests++; if (protocol_error !== 1'b0) begin fails++; $display("FAIL bread_no_perr: got %b want 0", protocol_error); end
      write_byte(1'b1, 8'h51); write_byte(1'b0, 8'h80);
      wait_ready();
      read_nibble(1'b1, nib, oe_hi, oe_after);
      tests++; if (nib !== 4'h5) begin fails++; $display("FAIL dread_hi: got %h want 5", nib); end
      read_nibble(1'b1, nib, oe_hi, oe_after);
      tests++; if (nib !== 4'h1) begin fails++; $display("FAIL dread_lo: got %h want 1", nib); end
      tests++; if (ac !== 7'h01) begin fails++; $display("FAIL dread_ac: got %h want 01", ac); end
   endtask

   task automatic test_protocol();
      logic [7:0] v;
      write_byte(1'b0, 8'h85); write_byte(1'b1, 8'h42);
      repeat (10) @(negedge clk);
      pulse(1'b1, 1'b0, 4'h5, EM);
      pulse(1'b1, 1'b0, 4'hA, EM);
      tests++; if (protocol_error !== 1'b1) begin fails++; $display("FAIL perr_set: got %b want 1", protocol_error); end
      tests++; if (byte_count !== 16'(exp_bc)) begin fails++; $display("FAIL perr_count: got %0d want %0d", byte_count, exp_bc); end
      tests++; if (ac !== 7'h06) begin fails++; $display("FAIL perr_ac: got %h want 06", ac); end
      peek(7'h06, v);
      tests++; if (v !== 8'h20) begin fails++; $display("FAIL perr_ddram: got %h want 20", v); end
      write_byte(1'b1, 8'h43);
      peek(7'h06, v);
      tests++; if (v !== 8'h43) begin fails++; $display("FAIL perr_recover: got %h want 43", v); end
      peek(7'h05, v);
      tests++; if (v !== 8'h42) begin fails++; $display("FAIL perr_prev_byte: got %h want 42", v); end
      tests++; if (byte_count !== 16'(exp_bc)) begin fails++; $display("FAIL perr_count_after: got %0d want %0d", byte_count, exp_bc); end
   endtask

   task automatic test_timing_clear();
      logic [7:0] v;
      tests++; if (timing_error !== 1'b0) begin fails++; $display("FAIL terr_before: got %b want 0", timing_error); end
      wait_ready();
      pulse(1'b0, 1'b0, 4'h0, 10);
      tests++; if (timing_error !== 1'b1) begin fails++; $display("FAIL terr_set: got %b want 1", timing_error); end
      @(negedge clk);
      Clear = 1'b1;
      @(negedge clk);
      Clear = 1'b0;
      tests++; if ({four_bit_mode, two_line, display_on, cursor_on, blink_on, busy, protocol_error, timing_error} !== 8'b0) begin
         fails++; $display("FAIL clear_flags: got %b want 00000000",
            {four_bit_mode, two_line, display_on, cursor_on, blink_on, busy, protocol_error, timing_error}); end
      tests++; if (ac !== 7'h00 || byte_count !== 16'd0 || rd_char !== 8'h00) begin
         fails++; $display("FAIL clear_regs: got %h/%0d/%h want 00/0/00", ac, byte_count, rd_char); end
      exp_bc = 0;
      pulse(1'b0, 1'b0, 4'hC, EM);
      tests++; if (ac !== 7'h40 || byte_count !== 16'd1) begin
         fails++; $display("FAIL clear_8bit_strobe: got %h/%0d want 40/1", ac, byte_count); end
      tests++; if (four_bit_mode !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL clear_8bit_mode: got %b%b want 01", four_bit_mode, busy); end
      peek(7'h05, v);
      tests++; if (v !== 8'h20) begin fails++; $display("FAIL clear_ddram: got %h want 20", v); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_text();
      test_wrap();
      test_busy_read();
      test_protocol();
      test_timing_clear();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
